// File: rtl/mem_map_pkg.sv
// Memory map shared by the CPU data-side logic: region bases, IO registers,
// DMA register addresses, DMA control bit positions and DMA state encoding.
package mem_map_pkg;

    localparam logic [15:0] TILEMAP_START     = 16'hC000;
    localparam logic [15:0] FRAMEBUFFER_START = 16'hE000;
    localparam logic [15:0] IO_START          = 16'hF000;

    localparam logic [15:0] PS2_REG     = 16'hFFF0;
    localparam logic [15:0] VSCROLL_REG = 16'hFFF1;
    localparam logic [15:0] HSCROLL_REG = 16'hFFF2;
    localparam logic [15:0] SCALE_REG   = 16'hFFF3;

    localparam logic [15:0] DMA_SRC_REG  = 16'hFFF8;
    localparam logic [15:0] DMA_DST_REG  = 16'hFFF9;
    localparam logic [15:0] DMA_LEN_REG  = 16'hFFFA;
    localparam logic [15:0] DMA_CTRL_REG = 16'hFFFB;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_FILL_BIT  = 1;
    localparam int CTRL_ABORT_BIT = 2;

    typedef logic [1:0] dma_state_t;
    localparam dma_state_t ST_IDLE  = 2'd0;
    localparam dma_state_t ST_RUN   = 2'd1;
    localparam dma_state_t ST_FLUSH = 2'd2;
    localparam dma_state_t ST_DONE  = 2'd3;

    // True when base..base+len-1 stays below the IO region (len must be non-zero).
    function automatic logic range_ok(input logic [15:0] base, input logic [15:0] len);
        logic [16:0] last;
        last = {1'b0, base} + {1'b0, len} - 17'd1;
        return last < {1'b0, IO_START};
    endfunction

endpackage

// File: rtl/dma_fifo.sv
// Read-data buffer between the memory read port and the DMA write side.
module dma_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != (AW+1)'(DEPTH));
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_dma_arbiter.sv
// Shares memory read port 1 and the write port between the CPU and a copy/fill DMA.
// Fill mode exists only when DMA_FILL_EN is defined; otherwise every transfer is a copy.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a CTRL write with start=1
// ST_RUN   | issuing reads into idle port-1 cycles, draining FIFO to dst
// ST_FLUSH | aborted: waiting for in-flight reads, FIFO held cleared
// ST_DONE  | single cycle, dma_done=1
module mem_dma_arbiter
    import mem_map_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ren,
    input  logic [15:0] cpu_raddr1,
    input  logic        cpu_wen,
    input  logic [15:0] cpu_waddr,
    input  logic [15:0] cpu_wdata,
    output logic        mem_ren,
    output logic [15:0] mem_raddr1,
    input  logic [15:0] mem_rdata1,
    output logic        mem_wen,
    output logic [15:0] mem_waddr,
    output logic [15:0] mem_wdata,
    output logic        dma_busy,
    output logic        dma_done,
    output logic        dma_err
);
    localparam int CW = $clog2(FIFO_DEPTH);

    dma_state_t        state;
    logic [15:0]       src_reg, dst_reg, len_reg;
    logic [15:0]       src_ptr, dst_ptr;
    logic [15:0]       rd_rem, wr_rem;
    logic [RD_LAT-1:0] tag_sr;
    logic [CW:0]       inflight;
    logic [CW:0]       fifo_count;
    logic [CW+1:0]     occupancy;
    logic [15:0]       fifo_dout;
    logic [15:0]       dma_wdata;
    logic              fifo_empty;
    logic              done_q;
    logic              busy, ctrl_wr, start_req, abort_req;
    logic              src_ok, start_ok, rd_allowed, wr_avail;
    logic              rd_issue, dma_wr, last_wr;

    assign busy      = (state != ST_IDLE);
    assign ctrl_wr   = cpu_wen && (cpu_waddr == DMA_CTRL_REG);
    assign start_req = ctrl_wr && cpu_wdata[CTRL_START_BIT] && !busy;
    assign abort_req = ctrl_wr && cpu_wdata[CTRL_ABORT_BIT];

`ifdef DMA_FILL_EN
    logic fill_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          fill_mode <= 1'b0;
        else if (state == ST_IDLE && start_req) fill_mode <= cpu_wdata[CTRL_FILL_BIT];
    end

    // Fill source is a data value, so only copies need a legal source range.
    assign src_ok     = cpu_wdata[CTRL_FILL_BIT] || range_ok(src_reg, len_reg);
    assign rd_allowed = !fill_mode;
    assign wr_avail   = fill_mode ? (wr_rem != 16'd0) : !fifo_empty;
    assign dma_wdata  = fill_mode ? src_reg : fifo_dout;
`else
    assign src_ok     = range_ok(src_reg, len_reg);
    assign rd_allowed = 1'b1;
    assign wr_avail   = !fifo_empty;
    assign dma_wdata  = fifo_dout;
`endif

    assign start_ok = range_ok(dst_reg, len_reg) && src_ok;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + (CW+1)'(tag_sr[i]);
    end

    // Reads already in the memory pipeline reserve FIFO space so pushes never overflow.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    assign rd_issue  = (state == ST_RUN) && rd_allowed && !cpu_ren && (rd_rem != 16'd0)
                       && (occupancy < (CW+2)'(FIFO_DEPTH));
    assign dma_wr    = (state == ST_RUN) && !cpu_wen && wr_avail;
    assign last_wr   = dma_wr && (wr_rem == 16'd1);

    dma_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_FLUSH),
        .push  (tag_sr[RD_LAT-1] && (state == ST_RUN)),
        .din   (mem_rdata1),
        .pop   (dma_wr),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
            src_ptr <= '0;
            dst_ptr <= '0;
            rd_rem  <= '0;
            wr_rem  <= '0;
            tag_sr  <= '0;
            done_q  <= 1'b0;
            dma_err <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tag_sr <= (tag_sr << 1) | RD_LAT'(rd_issue);

            if (cpu_wen && !busy) begin
                case (cpu_waddr)
                    DMA_SRC_REG: src_reg <= cpu_wdata;
                    DMA_DST_REG: dst_reg <= cpu_wdata;
                    DMA_LEN_REG: len_reg <= cpu_wdata;
                    default: ;
                endcase
            end

            if (rd_issue) begin
                src_ptr <= src_ptr + 16'd1;
                rd_rem  <= rd_rem - 16'd1;
            end
            if (dma_wr) begin
                dst_ptr <= dst_ptr + 16'd1;
                wr_rem  <= wr_rem - 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        if (len_reg == 16'd0) begin
                            done_q  <= 1'b1;
                            dma_err <= 1'b0;
                        end else if (!start_ok) begin
                            done_q  <= 1'b1;
                            dma_err <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            dma_err <= 1'b0;
                            src_ptr <= src_reg;
                            dst_ptr <= dst_reg;
                            rd_rem  <= len_reg;
                            wr_rem  <= len_reg;
                        end
                    end
                end
                ST_RUN: begin
                    // Completing the last write takes precedence over a coincident abort.
                    if (last_wr) begin
                        state <= ST_DONE;
                    end else if (abort_req) begin
                        state   <= ST_FLUSH;
                        dma_err <= 1'b1;
                    end
                end
                ST_FLUSH: if (inflight == '0) state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign dma_busy   = busy;
    assign dma_done   = done_q || (state == ST_DONE);
    assign mem_ren    = cpu_ren;
    assign mem_raddr1 = cpu_ren ? cpu_raddr1 : src_ptr;
    assign mem_wen    = cpu_wen || dma_wr;
    assign mem_waddr  = cpu_wen ? cpu_waddr : dst_ptr;
    assign mem_wdata  = cpu_wen ? cpu_wdata : dma_wdata;

endmodule

// File: tb/tb_mem_dma_arbiter.sv
// Directed bench for mem_dma_arbiter with a 2-cycle-latency memory model.
`timescale 1ns/1ps
module tb_mem_dma_arbiter;
    import mem_map_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_ren = 1'b0;
    logic [15:0] cpu_raddr1 = '0;
    logic        cpu_wen = 1'b0;
    logic [15:0] cpu_waddr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        mem_ren, mem_wen, dma_busy, dma_done, dma_err;
    logic [15:0] mem_raddr1, mem_rdata1, mem_waddr, mem_wdata;

    always #5 clk = ~clk;

    mem_dma_arbiter #(.RD_LAT(2), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_ren    (cpu_ren),
        .cpu_raddr1 (cpu_raddr1),
        .cpu_wen    (cpu_wen),
        .cpu_waddr  (cpu_waddr),
        .cpu_wdata  (cpu_wdata),
        .mem_ren    (mem_ren),
        .mem_raddr1 (mem_raddr1),
        .mem_rdata1 (mem_rdata1),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .dma_busy   (dma_busy),
        .dma_done   (dma_done),
        .dma_err    (dma_err)
    );

    logic [15:0] mem [0:65535];
    logic [15:0] rd_addr_q = '0;
    logic [15:0] rdata_q = '0;
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        rd_addr_q <= mem_raddr1;
        rdata_q   <= mem[rd_addr_q];
    end
    assign mem_rdata1 = rdata_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Log of DMA-originated writes and done pulses, sampled mid-cycle.
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int done_cyc_q[$];
    int max_fifo = 0;
    always @(negedge clk) begin
        if (mem_wen && !cpu_wen) begin
            wr_addr_q.push_back(int'(mem_waddr));
            wr_data_q.push_back(int'(mem_wdata));
            wr_cyc_q.push_back(cyc);
        end
        if (dma_done) done_cyc_q.push_back(cyc);
        if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] addr, input logic [15:0] data, output int c);
        cpu_waddr = addr;
        cpu_wdata = data;
        cpu_wen   = 1'b1;
        c         = cyc;
        step();
        cpu_wen   = 1'b0;
    endtask

    task automatic program_dma(input logic [15:0] src, input logic [15:0] dst,
                               input logic [15:0] len, input logic [15:0] ctrl, output int s);
        int c;
        cpu_wr(DMA_SRC_REG, src, c);
        cpu_wr(DMA_DST_REG, dst, c);
        cpu_wr(DMA_LEN_REG, len, c);
        cpu_wr(DMA_CTRL_REG, ctrl, s);
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        for (int i = 0; i < budget && done_cyc_q.size() == d0; i++) sample();
        check(tag, 32'(done_cyc_q.size() - d0), 32'd1);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, w0, d0, c, ws;
        bit fill_on;
        for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
        for (int i = 0; i < 16; i++) mem[16'h0100 + i] <= 16'h00A0 + 16'(i);
        for (int i = 0; i < 8; i++)  mem[16'h0F00 + i] <= 16'h00B0 + 16'(i);
        mem[16'h0200] <= 16'h1234;

        repeat (3) step();
        sample();
        check("rst_busy", 32'(dma_busy), 32'd0);
        check("rst_done", 32'(dma_done), 32'd0);
        check("rst_err", 32'(dma_err), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_raddr", 32'(mem_raddr1), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: plain copy, CPU idle
        w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
        program_dma(16'h0100, FRAMEBUFFER_START, 16'd4, 16'h0001, s);
        wait_done("s1_done", d0, 40);
        repeat (3) step();
        check("s1_nwr", 32'(wr_addr_q.size() - w0), 32'd4);
        for (int i = 0; i < 4 && w0 + i < wr_addr_q.size(); i++) begin
            check("s1_addr", 32'(wr_addr_q[w0+i]), 32'h0000E000 + 32'(i));
            check("s1_data", 32'(wr_data_q[w0+i]), 32'h000000A0 + 32'(i));
            check("s1_cyc", 32'(wr_cyc_q[w0+i]), 32'(s + 4 + i));
        end
        check("s1_ndone", 32'(done_cyc_q.size() - d0), 32'd1);
        if (done_cyc_q.size() > d0) check("s1_done_cyc", 32'(done_cyc_q[d0]), 32'(s + 8));
        check("s1_err", 32'(dma_err), 32'd0);
        check("s1_busy", 32'(dma_busy), 32'd0);

        // 2: copy with CPU reads and stores interleaved
        w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
        program_dma(16'h0100, 16'hE010, 16'd4, 16'h0001, s);
        for (int j = 0; j < 10; j++) begin
            cpu_ren    = (j == 1 || j == 2);
            cpu_raddr1 = 16'h0200;
            cpu_wen    = (j >= 4 && j <= 6);
            cpu_waddr  = 16'h0300 + 16'(j - 4);
            cpu_wdata  = 16'h5A00 + 16'(j);
            sample();
            if (cpu_ren) begin
                check("s2_raddr", 32'(mem_raddr1), 32'h00000200);
                check("s2_ren", 32'(mem_ren), 32'd1);
            end
            if (cpu_wen) begin
                check("s2_waddr", 32'(mem_waddr), 32'h00000300 + 32'(j - 4));
                check("s2_wdata", 32'(mem_wdata), 32'h00005A00 + 32'(j));
            end
            step();
        end
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        wait_done("s2_done", d0, 40);
        repeat (2) step();
        check("s2_nwr", 32'(wr_addr_q.size() - w0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("s2_fb", 32'(mem[16'hE010 + 16'(i)]), 32'h000000A0 + 32'(i));
        end
        for (int k = 0; k < 3; k++) begin
            check("s2_cpu_st", 32'(mem[16'h0300 + 16'(k)]), 32'h00005A04 + 32'(k));
        end
        check("s2_fifo_max", 32'(max_fifo <= 4), 32'd1);

        // 3: rejected starts, then an accepted boundary start clears the error
        w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
        program_dma(16'h0100, 16'hEFFE, 16'd3, 16'h0001, s);
        sample();
        check("s3_done", 32'(dma_done), 32'd1);
        check("s3_err", 32'(dma_err), 32'd1);
        check("s3_busy", 32'(dma_busy), 32'd0);
        sample();
        check("s3_done_once", 32'(dma_done), 32'd0);
        step();
        program_dma(16'hEFFF, 16'h0000, 16'd2, 16'h0001, s);
        sample();
        check("s3_src_rej", 32'(dma_err), 32'd1);
        check("s3_src_busy", 32'(dma_busy), 32'd0);
        step();
        check("s3_nwr", 32'(wr_addr_q.size() - w0), 32'd0);
        d0 = done_cyc_q.size();
        program_dma(16'h0100, 16'hEFFC, 16'd4, 16'h0001, s2);
        sample();
        check("s3_err_clr", 32'(dma_err), 32'd0);
        check("s3_run", 32'(dma_busy), 32'd1);
        wait_done("s3_ok_done", d0, 40);
        check("s3_last", 32'(mem[16'hEFFF]), 32'h000000A3);

        // 4: zero length
        d0 = done_cyc_q.size();
        program_dma(16'h0100, 16'hE030, 16'd0, 16'h0001, s);
        sample();
        check("s4_done", 32'(dma_done), 32'd1);
        check("s4_busy", 32'(dma_busy), 32'd0);
        sample();
        check("s4_done_end", 32'(dma_done), 32'd0);
        check("s4_busy2", 32'(dma_busy), 32'd0);
        step();

        // 5: abort after five writes
        w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
        program_dma(16'h0100, 16'hE040, 16'd16, 16'h0001, s);
        for (int i = 0; i < 100 && wr_addr_q.size() - w0 < 5; i++) sample();
        check("s5_reach5", 32'(wr_addr_q.size() - w0), 32'd5);
        step();
        cpu_wr(DMA_CTRL_REG, 16'h0004, c);
        sample();
        check("s5_flush", 32'(dut.state), 32'(ST_FLUSH));
        check("s5_busy", 32'(dma_busy), 32'd1);
        check("s5_nodone", 32'(dma_done), 32'd0);
        step();
        wait_done("s5_done", d0, 40);
        repeat (3) step();
        check("s5_nwr", 32'(wr_addr_q.size() - w0), 32'd5);
        check("s5_err", 32'(dma_err), 32'd1);
        check("s5_ndone", 32'(done_cyc_q.size() - d0), 32'd1);
        check("s5_mem", 32'(mem[16'hE045]), 32'd0);

        // 6: CTRL with fill bit; fill when built with it, copy otherwise
`ifdef DMA_FILL_EN
        fill_on = 1'b1;
`else
        fill_on = 1'b0;
`endif
        w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
        program_dma(16'h0F00, TILEMAP_START, 16'd8, 16'h0003, s);
        wait_done("s6_done", d0, 40);
        repeat (2) step();
        check("s6_nwr", 32'(wr_addr_q.size() - w0), 32'd8);
        check("s6_err", 32'(dma_err), 32'd0);
        for (int i = 0; i < 8 && w0 + i < wr_addr_q.size(); i++) begin
            check("s6_addr", 32'(wr_addr_q[w0+i]), 32'h0000C000 + 32'(i));
            check("s6_data", 32'(wr_data_q[w0+i]), fill_on ? 32'h00000F00 : 32'h000000B0 + 32'(i));
        end
        if (wr_cyc_q.size() > w0) check("s6_first_cyc", 32'(wr_cyc_q[w0]), 32'(s + (fill_on ? 1 : 4)));

        // reset mid-transfer
        d0 = done_cyc_q.size();
        program_dma(16'h0F00, 16'hC100, 16'd8, 16'h0003, s);
        step();
        step();
        rst_n = 1'b0;
        sample();
        check("s6_rst_busy", 32'(dma_busy), 32'd0);
        check("s6_rst_done", 32'(dma_done), 32'd0);
        check("s6_rst_err", 32'(dma_err), 32'd0);
        check("s6_rst_wen", 32'(mem_wen), 32'd0);
        ws = wr_addr_q.size();
        step();
        rst_n = 1'b1;
        repeat (12) step();
        check("s6_rst_nodone", 32'(done_cyc_q.size() - d0), 32'd0);
        check("s6_rst_nowr", 32'(wr_addr_q.size() - ws), 32'd0);
        check("s6_rst_mem", 32'(mem[16'hC107]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dma_arbiter.md
Name: mem_dma_arbiter

Overview:
Shares the memory block's read port 1 and its single write port between the CPU and an internal copy/fill DMA engine. The CPU always has priority. DMA traffic only uses port cycles the CPU leaves idle.
The CPU configures the DMA through memory-mapped IO registers that this block snoops off the write bus. Typical use is bulk framebuffer and tilemap updates.
Sits between the CPU data-side bus and the memory block. Port 0 (instruction fetch) bypasses this block.

Parameters:
RD_LAT, 2, cycles from the address on mem_raddr1 to valid mem_rdata1.
FIFO_DEPTH, 4, read-data buffer entries; power of two, at least RD_LAT+1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_ren  input  1  CPU load request on port 1
cpu_raddr1  input  16  CPU load address
cpu_wen  input  1  CPU store request
cpu_waddr  input  16  CPU store address
cpu_wdata  input  16  CPU store data
mem_ren  output  1  to memory, equals cpu_ren (DMA never asserts it, so the PS/2 read side-effect never fires)
mem_raddr1  output  16  CPU address when cpu_ren=1, otherwise the DMA read address
mem_rdata1  input  16  memory read data; also wired directly to the CPU at top level
mem_wen  output  1  memory write enable
mem_waddr  output  16  memory write address
mem_wdata  output  16  memory write data
dma_busy  output  1  high while the DMA is not IDLE
dma_done  output  1  one-cycle pulse when a transfer ends
dma_err  output  1  sticky; set by a rejected start or an abort, cleared by the next accepted start

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous and active-low. While rst_n=0, all state clears, FSM=IDLE, and every output register is 0.
- CPU pass-through: CPU stores always reach the memory in the same cycle (mem_wen=cpu_wen, with cpu_waddr and cpu_wdata). The config addresses below are also forwarded; the memory ignores them.
- Config registers, snooped on cpu_wen:
  - 0xFFF8 DMA_SRC: source address, or the fill value in fill mode.
  - 0xFFF9 DMA_DST.
  - 0xFFFA DMA_LEN: word count.
  - 0xFFFB DMA_CTRL: bit0 start, bit1 fill, bit2 abort.
  - SRC, DST and LEN writes are ignored while busy.
- Start validation, at the clock edge that captures a CTRL write with start=1 in IDLE:
  - LEN=0: no transfer; dma_done pulses the next cycle.
  - Reject if DST+LEN-1 > 0xEFFF or the sum overflows 16 bits.
  - In copy mode, also reject if SRC+LEN-1 > 0xEFFF. This keeps DMA out of the IO region.
  - On reject: dma_err=1, dma_done pulses, FSM stays in IDLE.
  - Otherwise: FSM=RUN and the read and write counters load LEN.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on an accepted start.
  - RUN→DONE when all LEN writes have completed.
  - RUN→FLUSH on abort.
  - FLUSH→DONE when the in-flight count reaches 0. The FIFO is discarded and dma_err is set.
  - DONE lasts one cycle (dma_done=1), then →IDLE.
- Read issue in RUN:
  - A DMA read is issued in any cycle with cpu_ren=0, reads remaining >0, and fifo_count+inflight < FIFO_DEPTH.
  - mem_raddr1 = src_ptr; src_ptr increments by 1.
  - A RD_LAT-deep valid shift register tags the DMA reads. A tagged mem_rdata1 is pushed into the FIFO.
  - CPU read cycles leave no tag, so their data never enters the FIFO.
- Write drain in RUN:
  - A DMA write happens when cpu_wen=0 and the FIFO is non-empty: pop the FIFO, write it to dst_ptr, increment dst_ptr.
  - When cpu_wen=1 the DMA write stalls that cycle.
- Fill mode: no reads are issued. A write of DMA_SRC to dst_ptr happens every cycle with cpu_wen=0.
- Latency, no contention: a read issued in cycle k returns in cycle k+RD_LAT and is written in cycle k+RD_LAT+1. Sustained throughput is 1 word per cycle.
- Simultaneous events:
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - An abort written in the same cycle as the last write is ignored; the FSM goes to DONE without error.
  - Start while busy is ignored.
- Reset mid-transfer: the transfer is abandoned immediately and there is no dma_done pulse.

Optional Feature:
DMA_FILL_EN.
- Defined: fill mode (CTRL bit1) is supported as described above.
- Undefined: bit1 is ignored, every transfer is a copy, and the fill datapath and mux are removed.

Decomposition:
- Shared package mem_map_pkg holds:
  - TILEMAP_START, FRAMEBUFFER_START, IO_START.
  - PS2_REG, VSCROLL_REG, HSCROLL_REG, SCALE_REG.
  - The new DMA_SRC/DST/LEN/CTRL addresses and the CTRL bit indices.
  - The FSM state enum.
- Sub-module dma_fifo: synchronous FIFO with parameterised depth, push/pop/count/empty, async active-low reset.

Test Plan:
1. SRC=0x0100 holding 0xA0..0xA3, DST=0xE000, LEN=4, CPU idle → four writes in consecutive cycles starting 3 cycles after start. Frame buffer 0xE000..3 = 0xA0..0xA3. dma_done pulses once; dma_err=0.
2. As scenario 1, with cpu_wen held high for 3 cycles mid-transfer and cpu_ren high for 2 cycles → CPU accesses complete unmodified, the DMA stalls, the final memory contents are identical, and the FIFO never exceeds 4 entries.
3. Start with DST=0xEFFE, LEN=3 → no memory writes, dma_err=1, dma_done pulse. A following valid start clears dma_err.
4. LEN=0 start → dma_busy never rises in RUN and dma_done pulses the next cycle.
5. LEN=16, abort written after 5 writes → no further writes once the abort is seen, FSM passes FLUSH, dma_done pulses, dma_err=1.
6. DMA_FILL_EN defined: SRC=0x0F00, DST=0xC000, LEN=8 → 0xC000..0xC007 = 0x0F00. Then assert rst_n=0 mid-transfer → outputs 0 and no done pulse.
